display_scan_scheduler: RTL and testbench

Sequencer for the 4-digit multiplexed 7-segment display. It time-slices the anodes with a programmable slot length and a dead-time blanking gap to prevent ghosting, and applies 8-level PWM brightness. It suppresses leading zeros on request and accepts new 16-bit display values through a valid/ready handshake. New values are committed only at frame boundaries, so the display never tears. It sits between the value producers (switch logic, counters) and the board seg/an pins.

---
 rtl/display_pkg.sv | 24 ++
 rtl/hex_to_seg.sv | 37 +++
 rtl/display_scan_scheduler.sv | 170 +++++++++++++++++
 tb/tb_display_scan_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the 4-digit multiplexed 7-segment display path:
// digit count, blank/off patterns for active-low segments and anodes, the
// per-slot scan state, and the anode one-hot-low decoder.
// -----------------------------------------------------------------------------
package display_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [3:0] AN_OFF     = 4'b1111;

    // DEAD: all anodes off (ghosting guard); ON: digit may be driven
    typedef enum logic {
        DEAD = 1'b0,
        ON   = 1'b1
    } scan_state_e;

    // Active-low one-hot anode pattern for a digit index
    function automatic logic [3:0] an_onehot_low(input logic [1:0] idx);
        an_onehot_low = ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// -----------------------------------------------------------------------------
// hex_to_seg
// Purely combinational nibble to active-low 7-segment decoder, 0-F.
// Ports:
//   nibble  in  [3:0]  hex digit to show
//   seg     out [0:6]  active-low segment pattern; literals below follow the
//                      board's conventional table (0 = segment lit)
// -----------------------------------------------------------------------------
module hex_to_seg (
    input  logic [3:0] nibble,
    output logic [0:6] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (nibble)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/display_scan_scheduler.sv
// -----------------------------------------------------------------------------
// display_scan_scheduler
// Time-slices the four anodes of a multiplexed 7-segment display. Each slot
// starts with DEAD_CYCLES of blanking, then an ON phase gated by 8-level PWM.
// New 16-bit values arrive through a valid/ready handshake into a shadow
// register and are committed only on the last cycle of the digit-3 slot, so a
// frame never mixes two values. Optional leading-zero suppression.
// All outputs decode registered state only.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   upd_valid/ready   handshake for upd_data (nibble 0 = rightmost digit)
//   brightness        duty level, 7 = full on, 0 = 1/8 (sampled per slot)
//   lz_blank_en       leading-zero suppression enable (sampled per slot)
//   seg, an           active-low segments a..g and anodes
//   digit_sel         digit currently scanned
//   frame_done        pulse on the last cycle of the digit-3 slot
// -----------------------------------------------------------------------------
module display_scan_scheduler
    import display_pkg::*;
#(
    parameter int SLOT_CYCLES = 250000,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        upd_valid,
    input  logic [15:0] upd_data,
    output logic        upd_ready,
    input  logic [2:0]  brightness,
    input  logic        lz_blank_en,
    output logic [0:6]  seg,
    output logic [3:0]  an,
    output logic [1:0]  digit_sel,
    output logic        frame_done
);

    localparam int               CNT_W     = $clog2(SLOT_CYCLES);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]       digit_q, digit_d;
    scan_state_e      state_q, state_d;
    logic [2:0]       pwm_q, pwm_d;
    logic [2:0]       bright_q, bright_d;
    logic             lz_en_q, lz_en_d;
    logic [15:0]      active_q, active_d;
    logic [15:0]      shadow_q, shadow_d;
    logic             pending_q, pending_d;

    logic             slot_wrap;
    logic             frame_end;
    logic             capture;
    logic [3:0]       nibble;
    logic             lz_blank;
    logic             drive;
    logic [0:6]       seg_raw;

    // Next-state logic
    always_comb begin
        slot_wrap  = (slot_cnt_q == SLOT_LAST);
        frame_end  = slot_wrap && (digit_q == 2'd3);
        // ready is simply "no value waiting in the shadow"
        capture    = upd_valid && !pending_q;

        slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + CNT_W'(1);
        digit_d    = slot_wrap ? digit_q + 2'd1 : digit_q;

        state_d    = state_q;
        pwm_d      = pwm_q;
        case (state_q)
            DEAD: begin
                if (slot_cnt_q == DEAD_LAST) begin
                    state_d = ON;
                    pwm_d   = 3'd0;
                end
            end
            ON: begin
                pwm_d = pwm_q + 3'd1;
                if (slot_wrap) begin
                    state_d = DEAD;
                end
            end
            default: state_d = DEAD;
        endcase

        // Per-slot controls are frozen for the slot so a digit never flickers
        // between duty levels or blank states mid-slot.
        bright_d = (slot_cnt_q == '0) ? brightness  : bright_q;
        lz_en_d  = (slot_cnt_q == '0) ? lz_blank_en : lz_en_q;

        shadow_d  = capture ? upd_data : shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (frame_end && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (capture) begin
            pending_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q <= '0;
            digit_q    <= 2'd0;
            state_q    <= DEAD;
            pwm_q      <= 3'd0;
            bright_q   <= 3'd0;
            lz_en_q    <= 1'b0;
            active_q   <= 16'h0000;
            shadow_q   <= 16'h0000;
            pending_q  <= 1'b0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            digit_q    <= digit_d;
            state_q    <= state_d;
            pwm_q      <= pwm_d;
            bright_q   <= bright_d;
            lz_en_q    <= lz_en_d;
            active_q   <= active_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
        end
    end

    // Output decode from registered state
    always_comb begin
        nibble   = active_q[3:0];
        lz_blank = 1'b0;
        case (digit_q)
            2'd0: begin
                nibble   = active_q[3:0];
                lz_blank = 1'b0;
            end
            2'd1: begin
                nibble   = active_q[7:4];
                lz_blank = lz_en_q && (active_q[15:4] == 12'h000);
            end
            2'd2: begin
                nibble   = active_q[11:8];
                lz_blank = lz_en_q && (active_q[15:8] == 8'h00);
            end
            2'd3: begin
                nibble   = active_q[15:12];
                lz_blank = lz_en_q && (active_q[15:12] == 4'h0);
            end
            default: begin
                nibble   = active_q[3:0];
                lz_blank = 1'b0;
            end
        endcase

        drive = (state_q == ON) && (pwm_q <= bright_q) && !lz_blank;
    end

    hex_to_seg u_hex_to_seg (
        .nibble (nibble),
        .seg    (seg_raw)
    );

    assign an         = drive ? an_onehot_low(digit_q) : AN_OFF;
    assign seg        = drive ? seg_raw : SEG_BLANK;
    assign digit_sel  = digit_q;
    assign frame_done = frame_end;
    assign upd_ready  = !pending_q;

endmodule

// File: tb/tb_display_scan_scheduler.sv
module tb_display_scan_scheduler;

    localparam int SLOT  = 16;
    localparam int DEAD  = 2;
    localparam int FRAME = 64;

    localparam logic [6:0] S_0 = 7'b1000000;
    localparam logic [6:0] S_1 = 7'b1111001;
    localparam logic [6:0] S_2 = 7'b0100100;
    localparam logic [6:0] S_3 = 7'b0110000;
    localparam logic [6:0] S_4 = 7'b0011001;
    localparam logic [6:0] S_5 = 7'b0010010;
    localparam logic [6:0] S_8 = 7'b0000000;
    localparam logic [6:0] S_A = 7'b0001000;
    localparam logic [6:0] S_B = 7'b0000011;
    localparam logic [6:0] S_C = 7'b1000110;
    localparam logic [6:0] S_F = 7'b0001110;
    localparam logic [6:0] S_X = 7'b1111111;

    logic        clk;
    logic        rst_n;
    logic        upd_valid;
    logic [15:0] upd_data;
    logic        upd_ready;
    logic [2:0]  brightness;
    logic        lz_blank_en;
    logic [0:6]  seg;
    logic [3:0]  an;
    logic [1:0]  digit_sel;
    logic        frame_done;

    display_scan_scheduler #(
        .SLOT_CYCLES (SLOT),
        .DEAD_CYCLES (DEAD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .upd_valid   (upd_valid),
        .upd_data    (upd_data),
        .upd_ready   (upd_ready),
        .brightness  (brightness),
        .lz_blank_en (lz_blank_en),
        .seg         (seg),
        .an          (an),
        .digit_sel   (digit_sel),
        .frame_done  (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] val;
        logic [2:0]  br;
        logic        lz;
        int          p;
        logic [3:0]  exp_an;
        logic [6:0]  exp_seg;
    } vec_t;

    vec_t vecs[$];

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int pos      = 0;

    logic [15:0] cur_val;
    logic [2:0]  cur_br;
    logic        cur_lz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (frame pos %0d, t=%0t)",
                     name, act, exp, pos % FRAME, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        pos++;
    endtask

    task automatic goto(input int p);
        int n;
        n = 0;
        while (((pos % FRAME) != p) && (n < 200)) begin
            step();
            n++;
        end
        if (n >= 200) begin
            tot_cnt++;
            $display("FAIL goto_timeout: got pos %0d expected %0d", pos % FRAME, p);
        end
    endtask

    // Offer a value, wait for its commit, and leave the bench at the start
    // of the first frame that shows it.
    task automatic load(input logic [15:0] v, input logic [2:0] br, input logic lz);
        int n;
        brightness  = br;
        lz_blank_en = lz;
        n = 0;
        while ((upd_ready !== 1'b1) && (n < 300)) begin
            step();
            n++;
        end
        if (n >= 300) begin
            tot_cnt++;
            $display("FAIL ready_timeout: got %0b expected 1", upd_ready);
        end
        upd_valid = 1'b1;
        upd_data  = v;
        step();
        upd_valid = 1'b0;
        if ((pos % FRAME) == 0) begin
            step();
        end
        goto(0);
        cur_val = v;
        cur_br  = br;
        cur_lz  = lz;
    endtask

    task automatic add_vec(input logic [15:0] val, input logic [2:0] br, input logic lz,
                           input int p, input logic [3:0] ea, input logic [6:0] es);
        vec_t v;
        v.val = val; v.br = br; v.lz = lz; v.p = p; v.exp_an = ea; v.exp_seg = es;
        vecs.push_back(v);
    endtask

    initial begin
        int fd_bad;
        int fd_pulses;
        int rdy_bad;

        // value 0x1234, full brightness
        add_vec(16'h1234, 3'd7, 1'b0,  0, 4'b1111, S_X);
        add_vec(16'h1234, 3'd7, 1'b0,  1, 4'b1111, S_X);
        add_vec(16'h1234, 3'd7, 1'b0,  2, 4'b1110, S_4);
        add_vec(16'h1234, 3'd7, 1'b0, 15, 4'b1110, S_4);
        add_vec(16'h1234, 3'd7, 1'b0, 16, 4'b1111, S_X);
        add_vec(16'h1234, 3'd7, 1'b0, 18, 4'b1101, S_3);
        add_vec(16'h1234, 3'd7, 1'b0, 34, 4'b1011, S_2);
        add_vec(16'h1234, 3'd7, 1'b0, 50, 4'b0111, S_1);
        add_vec(16'h1234, 3'd7, 1'b0, 63, 4'b0111, S_1);
        // brightness 0: on only at slot cycles 2 and 10
        add_vec(16'h0008, 3'd0, 1'b0,  2, 4'b1110, S_8);
        add_vec(16'h0008, 3'd0, 1'b0,  3, 4'b1111, S_X);
        add_vec(16'h0008, 3'd0, 1'b0,  9, 4'b1111, S_X);
        add_vec(16'h0008, 3'd0, 1'b0, 10, 4'b1110, S_8);
        add_vec(16'h0008, 3'd0, 1'b0, 11, 4'b1111, S_X);
        add_vec(16'h0008, 3'd0, 1'b0, 50, 4'b0111, S_0);
        // brightness 3: on at slot cycles 2-5 and 10-13
        add_vec(16'h0008, 3'd3, 1'b0,  5, 4'b1110, S_8);
        add_vec(16'h0008, 3'd3, 1'b0,  6, 4'b1111, S_X);
        add_vec(16'h0008, 3'd3, 1'b0, 13, 4'b1110, S_8);
        add_vec(16'h0008, 3'd3, 1'b0, 14, 4'b1111, S_X);
        add_vec(16'h0008, 3'd3, 1'b0, 21, 4'b1101, S_0);
        add_vec(16'h0008, 3'd3, 1'b0, 22, 4'b1111, S_X);
        // leading-zero suppression
        add_vec(16'h0050, 3'd7, 1'b1,  2, 4'b1110, S_0);
        add_vec(16'h0050, 3'd7, 1'b1, 18, 4'b1101, S_5);
        add_vec(16'h0050, 3'd7, 1'b1, 34, 4'b1111, S_X);
        add_vec(16'h0050, 3'd7, 1'b1, 50, 4'b1111, S_X);
        add_vec(16'h0000, 3'd7, 1'b1,  2, 4'b1110, S_0);
        add_vec(16'h0000, 3'd7, 1'b1, 18, 4'b1111, S_X);
        add_vec(16'h0000, 3'd7, 1'b1, 34, 4'b1111, S_X);
        add_vec(16'h0000, 3'd7, 1'b1, 50, 4'b1111, S_X);
        add_vec(16'h0A0B, 3'd7, 1'b1,  2, 4'b1110, S_B);
        add_vec(16'h0A0B, 3'd7, 1'b1, 18, 4'b1101, S_0);
        add_vec(16'h0A0B, 3'd7, 1'b1, 34, 4'b1011, S_A);
        add_vec(16'h0A0B, 3'd7, 1'b1, 50, 4'b1111, S_X);
        add_vec(16'hF00F, 3'd7, 1'b1, 34, 4'b1011, S_0);
        add_vec(16'hF00F, 3'd7, 1'b1, 50, 4'b0111, S_F);

        // reset state
        rst_n       = 1'b0;
        upd_valid   = 1'b0;
        upd_data    = 16'h0000;
        brightness  = 3'd7;
        lz_blank_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_an",         an,         4'b1111);
        chk("reset_seg",        seg,        S_X);
        chk("reset_ready",      upd_ready,  1'b1);
        chk("reset_frame_done", frame_done, 1'b0);
        chk("reset_digit_sel",  digit_sel,  2'd0);

        @(negedge clk);
        rst_n = 1'b1;
        pos   = 0;

        // first handshake and pre-commit display of 0
        upd_valid = 1'b1;
        upd_data  = 16'h1234;
        step();
        upd_valid = 1'b0;
        chk("ready_low_after_capture", upd_ready, 1'b0);
        goto(2);
        chk("precommit_an",  an,  4'b1110);
        chk("precommit_seg", seg, S_0);
        goto(0);
        chk("ready_after_first_commit", upd_ready, 1'b1);
        cur_val = 16'h1234;
        cur_br  = 3'd7;
        cur_lz  = 1'b0;

        // table-driven display checks
        foreach (vecs[i]) begin
            if ((vecs[i].val !== cur_val) || (vecs[i].br !== cur_br) || (vecs[i].lz !== cur_lz))
                load(vecs[i].val, vecs[i].br, vecs[i].lz);
            goto(vecs[i].p);
            chk($sformatf("vec%0d_an", i),    an,        vecs[i].exp_an);
            chk($sformatf("vec%0d_seg", i),   seg,       vecs[i].exp_seg);
            chk($sformatf("vec%0d_digit", i), digit_sel, vecs[i].p / SLOT);
        end

        // frame_done only on the last cycle of each frame
        goto(0);
        fd_bad    = 0;
        fd_pulses = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            if (frame_done !== ((pos % FRAME) == FRAME - 1)) fd_bad++;
            if (frame_done === 1'b1) fd_pulses++;
            step();
        end
        chk("frame_done_pattern_errors", fd_bad,    0);
        chk("frame_done_pulses",         fd_pulses, 2);

        // back-to-back updates with valid held
        load(16'h1111, 3'd7, 1'b0);
        goto(5);
        upd_valid = 1'b1;
        upd_data  = 16'hAAAA;
        step();
        upd_data  = 16'hBBBB;
        rdy_bad   = 0;
        while ((pos % FRAME) != 0) begin
            if (upd_ready !== 1'b0) rdy_bad++;
            step();
        end
        chk("b2b_ready_held_low_errors", rdy_bad,   0);
        chk("b2b_ready_after_commit",    upd_ready, 1'b1);
        step();
        upd_valid = 1'b0;
        chk("b2b_second_captured", upd_ready, 1'b0);
        goto(2);
        chk("b2b_frame1_d0", seg, S_A);
        goto(50);
        chk("b2b_frame1_d3_an",  an,  4'b0111);
        chk("b2b_frame1_d3_seg", seg, S_A);
        goto(0);
        goto(2);
        chk("b2b_frame2_d0", seg, S_B);

        // capture on the frame_done cycle defers by one frame
        goto(FRAME - 1);
        chk("fd_cycle_frame_done", frame_done, 1'b1);
        upd_valid = 1'b1;
        upd_data  = 16'h0C0C;
        step();
        upd_valid = 1'b0;
        chk("fd_cycle_captured", upd_ready, 1'b0);
        goto(2);
        chk("fd_cycle_not_committed", seg, S_B);
        goto(0);
        goto(2);
        chk("fd_cycle_committed_d0", seg, S_C);
        goto(18);
        chk("fd_cycle_committed_d1", seg, S_0);

        // asynchronous reset mid-scan with an update pending
        load(16'h1234, 3'd7, 1'b0);
        upd_valid = 1'b1;
        upd_data  = 16'h5678;
        step();
        upd_valid = 1'b0;
        chk("rst_pending_set", upd_ready, 1'b0);
        goto(40);
        chk("rst_pre_an",  an,  4'b1011);
        chk("rst_pre_seg", seg, S_2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_an",    an,        4'b1111);
        chk("rst_async_seg",   seg,       S_X);
        chk("rst_async_ready", upd_ready, 1'b1);
        chk("rst_async_digit", digit_sel, 2'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pos   = 0;
        #1;
        chk("rst_release_dead_an", an, 4'b1111);
        goto(2);
        chk("rst_after_d0_an",  an,  4'b1110);
        chk("rst_after_d0_seg", seg, S_0);
        goto(34);
        chk("rst_after_d2_an",  an,  4'b1011);
        chk("rst_after_d2_seg", seg, S_0);
        goto(0);
        goto(2);
        chk("rst_pending_discarded", seg, S_0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
